// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave byte receiver: oversampled SDA/SCL, address match with ACK,
// received bytes handed downstream over a one-entry valid/ready buffer.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   IDLE     | bus free or not addressed, waiting for START
//   ADDR     | shifting in 7-bit address plus R/W bit
//   ADDR_ACK | holding SDA low for the address ACK clock
//   DATA     | shifting in a data byte
//   DATA_ACK | holding SDA low for the data ACK clock
//   IGNORE   | not addressed or overrun; wait for START/STOP
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h2A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i2c_wb_clk_i,
    input  logic       i2c_wb_rst_i,
    input  logic       i2c_data_in,
    input  logic       i2c_clk_in,
    output logic       sda_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       frame_start_o,
    output logic       frame_end_o,
    output logic       overrun_o
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_DATA_ACK = 3'd4;
    localparam logic [2:0] ST_IGNORE   = 3'd5;

    logic [SYNC_STAGES-1:0] sda_sync;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic                   sda_prev;
    logic                   scl_prev;

    // Synchronizers reset to the idle-bus level so reset release never fakes an event.
    always_ff @(posedge i2c_wb_clk_i or posedge i2c_wb_rst_i) begin
        if (i2c_wb_rst_i) begin
            sda_sync <= '1;
            scl_sync <= '1;
            sda_prev <= 1'b1;
            scl_prev <= 1'b1;
        end else begin
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_data_in};
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_clk_in};
            sda_prev <= sda_sync[SYNC_STAGES-1];
            scl_prev <= scl_sync[SYNC_STAGES-1];
        end
    end

    logic sda_s;
    logic scl_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

    logic [2:0] state;
    logic [6:0] shift_reg;
    logic [2:0] bit_cnt;
    logic       ack_pend;
    logic       frame_active;

    logic [7:0] byte_next;
    logic       last_bit;
    logic       buf_free;

    assign byte_next = {shift_reg, sda_s};
    assign last_bit  = (bit_cnt == 3'd7);
    assign buf_free  = ~rx_valid_o | rx_ready_i;

    always_ff @(posedge i2c_wb_clk_i or posedge i2c_wb_rst_i) begin
        if (i2c_wb_rst_i) begin
            state         <= ST_IDLE;
            shift_reg     <= 7'd0;
            bit_cnt       <= 3'd0;
            ack_pend      <= 1'b0;
            frame_active  <= 1'b0;
            sda_oe_o      <= 1'b0;
            rx_data_o     <= 8'h00;
            rx_valid_o    <= 1'b0;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            // A load later in this block overrides the consume.
            if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end

            if (stop_det) begin
                state    <= ST_IDLE;
                sda_oe_o <= 1'b0;
                ack_pend <= 1'b0;
                if (frame_active) begin
                    frame_end_o  <= 1'b1;
                    frame_active <= 1'b0;
                end
            end else if (start_det) begin
                state     <= ST_ADDR;
                sda_oe_o  <= 1'b0;
                ack_pend  <= 1'b0;
                bit_cnt   <= 3'd0;
                overrun_o <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        sda_oe_o <= 1'b0;
                    end
                    ST_ADDR: begin
                        if (scl_rise && !ack_pend) begin
                            shift_reg <= byte_next[6:0];
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                if (byte_next[7:1] == SLAVE_ADDR && !byte_next[0]) begin
                                    ack_pend <= 1'b1;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end
                        end else if (scl_fall && ack_pend) begin
                            ack_pend <= 1'b0;
                            sda_oe_o <= 1'b1;
                            state    <= ST_ADDR_ACK;
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            sda_oe_o      <= 1'b0;
                            frame_start_o <= 1'b1;
                            frame_active  <= 1'b1;
                            bit_cnt       <= 3'd0;
                            state         <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (scl_rise && !ack_pend) begin
                            shift_reg <= byte_next[6:0];
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                if (buf_free) begin
                                    rx_data_o  <= byte_next;
                                    rx_valid_o <= 1'b1;
                                    ack_pend   <= 1'b1;
                                end else begin
                                    overrun_o <= 1'b1;
                                    state     <= ST_IGNORE;
                                end
                            end
                        end else if (scl_fall && ack_pend) begin
                            ack_pend <= 1'b0;
                            sda_oe_o <= 1'b1;
                            state    <= ST_DATA_ACK;
                        end
                    end
                    ST_DATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe_o <= 1'b0;
                            bit_cnt  <= 3'd0;
                            state    <= ST_DATA;
                        end
                    end
                    ST_IGNORE: begin
                        sda_oe_o <= 1'b0;
                    end
                    default: begin
                        sda_oe_o <= 1'b0;
                        state    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-banged I2C master, transaction-level model of the
// one-entry receive buffer, monitor capturing pulses and consumed bytes.
module tb_i2c_slave_rx;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       m_sda    = 1'b1;
    logic       m_scl    = 1'b1;
    logic       rx_ready = 1'b0;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_start;
    logic       frame_end;
    logic       overrun;

    assign sda_line = m_sda & ~sda_oe;

    i2c_slave_rx #(.SLAVE_ADDR(7'h2A), .SYNC_STAGES(2)) dut (
        .i2c_wb_clk_i (clk),
        .i2c_wb_rst_i (rst),
        .i2c_data_in  (sda_line),
        .i2c_clk_in   (m_scl),
        .sda_oe_o     (sda_oe),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .rx_ready_i   (rx_ready),
        .frame_start_o(frame_start),
        .frame_end_o  (frame_end),
        .overrun_o    (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #600_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "timeout");
    end

    // Monitor samples mid-cycle, away from the active edge and from input changes.
    int         fs_cnt = 0, fe_cnt = 0, oe_cnt = 0, valid_cnt = 0, stab_err = 0;
    logic [7:0] got_q[$];
    logic       prev_valid = 1'b0, prev_cons = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (frame_start === 1'b1) fs_cnt <= fs_cnt + 1;
        if (frame_end === 1'b1)   fe_cnt <= fe_cnt + 1;
        if (sda_oe === 1'b1)      oe_cnt <= oe_cnt + 1;
        if (rx_valid === 1'b1)    valid_cnt <= valid_cnt + 1;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) got_q.push_back(rx_data);
        if (rx_valid === 1'b1 && prev_valid && !prev_cons && rx_data !== prev_data)
            stab_err <= stab_err + 1;
        prev_valid <= (rx_valid === 1'b1);
        prev_cons  <= (rx_valid === 1'b1 && rx_ready === 1'b1);
        prev_data  <= rx_data;
    end

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Transaction-level reference model.
    bit         ready_tied = 1'b0;
    bit         e_full = 1'b0, e_ovr = 1'b0, e_ign = 1'b1, e_active = 1'b0;
    logic [7:0] e_held = 8'h00;
    int         e_fs = 0, e_fe = 0;
    logic [7:0] exp_q[$];
    int         chk_idx = 0;

    task automatic model_byte(input logic [7:0] b, input bit pulse, output bit exp_ack);
        if (pulse && e_full) begin
            exp_q.push_back(e_held);
            e_full = 1'b0;
        end
        if (e_ign) begin
            exp_ack = 1'b0;
        end else if (!e_full) begin
            exp_ack = 1'b1;
            e_held  = b;
            e_full  = 1'b1;
            if (ready_tied) begin
                exp_q.push_back(b);
                e_full = 1'b0;
            end
        end else begin
            exp_ack = 1'b0;
            e_ovr   = 1'b1;
            e_ign   = 1'b1;
        end
    endtask

    task automatic model_reset();
        e_full = 1'b0; e_held = 8'h00; e_ovr = 1'b0; e_ign = 1'b1; e_active = 1'b0;
    endtask

    task automatic send_raw(input logic [7:0] b, input bit pulse, input bit abort, output bit ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i];
            tick(4);
            m_scl = 1'b1;
            if (pulse && i == 0) begin
                tick(2); rx_ready = 1'b1; tick(1); rx_ready = 1'b0; tick(5);
            end else begin
                tick(8);
            end
            m_scl = 1'b0;
            tick(4);
        end
        ack = 1'b0;
        if (abort) return;
        m_sda = 1'b1;
        tick(4);
        m_scl = 1'b1;
        tick(4);
        ack = (sda_line === 1'b0);
        tick(4);
        m_scl = 1'b0;
        tick(4);
    endtask

    task automatic do_start();
        m_sda = 1'b0; tick(8); m_scl = 1'b0; tick(4);
        e_ovr = 1'b0; e_ign = 1'b0;
    endtask

    task automatic do_rstart();
        m_sda = 1'b1; tick(4); m_scl = 1'b1; tick(8); m_sda = 1'b0; tick(8); m_scl = 1'b0; tick(4);
        e_ovr = 1'b0; e_ign = 1'b0;
    endtask

    task automatic do_stop();
        m_sda = 1'b0; tick(4); m_scl = 1'b1; tick(8); m_sda = 1'b1; tick(8);
        if (e_active) begin
            e_fe++;
            e_active = 1'b0;
        end
        e_ign = 1'b1;
    endtask

    task automatic do_addr(input logic [6:0] a, input bit rw);
        bit ack, exp_ack;
        exp_ack = (a == 7'h2A) && !rw;
        send_raw({a, rw}, 1'b0, 1'b0, ack);
        check("addr_ack", 32'(ack), 32'(exp_ack));
        if (exp_ack) begin
            e_fs++;
            e_active = 1'b1;
        end else begin
            e_ign = 1'b1;
        end
    endtask

    task automatic do_byte(input logic [7:0] b, input bit pulse);
        bit ack, exp_ack;
        model_byte(b, pulse, exp_ack);
        send_raw(b, pulse, 1'b0, ack);
        check("data_ack", 32'(ack), 32'(exp_ack));
        check("overrun", 32'(overrun), 32'(e_ovr));
        check("rx_valid", 32'(rx_valid), 32'(e_full));
        if (e_full) check("rx_data_held", 32'(rx_data), 32'(e_held));
    endtask

    task automatic set_ready(input bit v);
        rx_ready   = v;
        ready_tied = v;
        if (v && e_full) begin
            exp_q.push_back(e_held);
            e_full = 1'b0;
        end
        tick(3);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = chk_idx; i < exp_q.size() && i < got_q.size(); i++)
            check(tag, 32'(got_q[i]), 32'(exp_q[i]));
        chk_idx = exp_q.size();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sda_oe"}, 32'(sda_oe), 32'd0);
        check({tag, "_rx_data"}, 32'(rx_data), 32'h00);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_fstart"}, 32'(frame_start), 32'd0);
        check({tag, "_fend"}, 32'(frame_end), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        int         oe0, v0;
        bit         ack, exp_ack;
        logic [6:0] ra;
        logic [7:0] rb, rb2;

        #1 rst = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(4);

        // Matching write, ready tied high, directed then random bytes.
        set_ready(1'b1);
        v0 = valid_cnt;
        do_start();
        do_addr(7'h2A, 1'b0);
        check("fstart_once", fs_cnt, e_fs);
        do_byte(8'hA5, 1'b0);
        do_byte(8'h3C, 1'b0);
        for (int i = 0; i < 3; i++) do_byte(8'($urandom_range(0, 255)), 1'b0);
        do_stop();
        check("fend_once", fe_cnt, e_fe);
        check("valid_one_cycle", valid_cnt - v0, 5);
        check_stream("stream_basic");

        // Non-matching address and a read request: never pulled low.
        oe0 = oe_cnt;
        do_start();
        do_addr(7'h2B, 1'b0);
        do_byte(8'($urandom_range(0, 255)), 1'b0);
        do_stop();
        do_start();
        do_addr(7'h2A, 1'b1);
        do_stop();
        ra = 7'($urandom_range(0, 127));
        if (ra == 7'h2A) ra = 7'h2B;
        do_start();
        do_addr(ra, 1'($urandom_range(0, 1)));
        do_byte(8'($urandom_range(0, 255)), 1'b0);
        do_stop();
        check("nack_no_oe", oe_cnt - oe0, 0);
        check("nack_fstart", fs_cnt, e_fs);
        check("nack_fend", fe_cnt, e_fe);
        check_stream("stream_nack");

        // Overrun: ready low, second byte NACKed, later bytes ignored.
        set_ready(1'b0);
        do_start();
        do_addr(7'h2A, 1'b0);
        do_byte(8'h11, 1'b0);
        do_byte(8'h22, 1'b0);
        do_byte(8'h33, 1'b0);
        check("ovr_data_kept", 32'(rx_data), 32'h11);
        do_rstart();
        check("ovr_cleared", 32'(overrun), 32'(e_ovr));
        do_addr(7'h2A, 1'b0);
        do_stop();
        check("ovr_fend", fe_cnt, e_fe);
        set_ready(1'b1);
        check_stream("stream_ovr");

        // Repeated start inside one frame.
        do_start();
        do_addr(7'h2A, 1'b0);
        do_byte(8'h55, 1'b0);
        do_rstart();
        check("rstart_no_fend", fe_cnt, e_fe);
        do_addr(7'h2A, 1'b0);
        check("rstart_fstart", fs_cnt, e_fs);
        do_byte(8'h66, 1'b0);
        do_stop();
        check("rstart_fend", fe_cnt, e_fe);
        check_stream("stream_rstart");

        // Consume exactly on the cycle the next byte lands.
        set_ready(1'b0);
        rb  = 8'($urandom_range(0, 255));
        rb2 = 8'($urandom_range(0, 255));
        do_start();
        do_addr(7'h2A, 1'b0);
        do_byte(rb, 1'b0);
        do_byte(rb2, 1'b1);
        check("pulse_valid", 32'(rx_valid), 32'd1);
        check("pulse_data", 32'(rx_data), 32'(rb2));
        check("pulse_no_ovr", 32'(overrun), 32'd0);
        set_ready(1'b1);
        do_stop();
        check_stream("stream_pulse");

        // Async reset while SDA is held low for a data ACK.
        do_start();
        do_addr(7'h2A, 1'b0);
        rb = 8'($urandom_range(0, 255));
        model_byte(rb, 1'b0, exp_ack);
        send_raw(rb, 1'b0, 1'b1, ack);
        check("oe_before_rst", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        #1;
        check("oe_async_rst", 32'(sda_oe), 32'd0);
        model_reset();
        m_sda = 1'b1;
        m_scl = 1'b1;
        tick(3);
        check_reset_outputs("midrst");
        rst = 1'b0;
        tick(4);
        do_start();
        do_addr(7'h2A, 1'b0);
        do_byte(8'($urandom_range(0, 255)), 1'b0);
        do_stop();
        check("post_rst_fstart", fs_cnt, e_fs);
        check("post_rst_fend", fe_cnt, e_fe);
        check_stream("stream_post_rst");

        check("data_stable_while_valid", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
